pid_ctrl: RTL and testbench

Parametrised fixed-point PID controller with conditional-integration anti-windup, output clamping and a valid/ready sample interface. It sits between the Kalman-filtered state estimate (`xf`) and the actuator/PWM stage. It computes one control update per accepted sample using a single time-shared signed Q-format multiplier sequenced by a small FSM.

---
 rtl/pid_ctrl_if.sv | 25 ++
 rtl/pid_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pid_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pid_ctrl_if.sv
// Sample/result handshake bundle for pid_ctrl.
// valid/ready: a sample transfers on a rising clk edge where in_valid && in_ready;
// out_valid is a one-cycle pulse with vc/sat_* already updated and held afterwards.
interface pid_ctrl_if #(
    parameter int N = 32
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] xref;
    logic signed [N-1:0] xf;
    logic                out_valid;
    logic signed [N-1:0] vc;
    logic                sat_hi;
    logic                sat_lo;

    modport master (
        output in_valid, xref, xf,
        input  in_ready, out_valid, vc, sat_hi, sat_lo
    );

    modport slave (
        input  in_valid, xref, xf,
        output in_ready, out_valid, vc, sat_hi, sat_lo
    );
endinterface

// File: rtl/pid_ctrl.sv
// Fixed-point PID controller: one shared rounding Q-multiplier time-sliced over P/I/D,
// conditional-integration anti-windup and clamped output.
module pid_ctrl #(
    parameter int                N    = 32,
    parameter int                Q    = 28,
    parameter logic signed [N-1:0] KP   = 32'sh1000_0000,
    parameter logic signed [N-1:0] KI   = 32'sh1000_0000,
    parameter logic signed [N-1:0] KD   = 32'sh0000_0000,
    parameter logic signed [N-1:0] VMIN = 32'sh0010_0000,
    parameter logic signed [N-1:0] VMAX = 32'sh4000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    pid_ctrl_if.slave  bus,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_P  = 3'd1,
        MUL_I  = 3'd2,
        MUL_D  = 3'd3,
        UPDATE = 3'd4
    } state_t;

    localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [2*N:0] RND  = {{(2*N){1'b0}}, 1'b1} << (Q-1);

    state_t              state;
    logic                out_valid_q;
    logic signed [N-1:0] vc_q;
    logic                sat_hi_q;
    logic                sat_lo_q;
    logic signed [N-1:0] i_acc;
    logic signed [N-1:0] e_prev;
    logic signed [N-1:0] e;
    logic signed [N-1:0] d;
    logic signed [N-1:0] p;
    logic signed [N-1:0] it;
    logic signed [N-1:0] dt;

    // Saturate an (N+1)-bit two-operand sum/difference to N bits.
    function automatic logic signed [N-1:0] sat1(input logic [N:0] v);
        if (v[N] != v[N-1]) return v[N] ? SMIN : SMAX;
        return v[N-1:0];
    endfunction

    // Saturate an (N+2)-bit three-operand sum to N bits.
    function automatic logic signed [N-1:0] sat2(input logic [N+1:0] v);
        if ((v[N+1] != v[N]) || (v[N] != v[N-1])) return v[N+1] ? SMIN : SMAX;
        return v[N-1:0];
    endfunction

    // Error and derivative of the incoming sample.
    logic signed [N-1:0] e_new;
    logic signed [N-1:0] d_new;
    always_comb begin
        e_new = sat1({bus.xref[N-1], bus.xref} - {bus.xf[N-1], bus.xf});
        d_new = sat1({e_new[N-1], e_new} - {e_prev[N-1], e_prev});
    end

    // Shared multiplier: operand pair selected by the current multiply state.
    logic signed [N-1:0]   mul_a;
    logic signed [N-1:0]   mul_b;
    logic signed [2*N-1:0] mul_a_ext;
    logic signed [2*N-1:0] mul_b_ext;
    logic signed [2*N-1:0] prod;
    logic signed [2*N:0]   prod_rnd;
    logic signed [2*N:0]   prod_sh;
    logic signed [N-1:0]   mul_q;
    always_comb begin
        mul_a = KP;
        mul_b = e;
        case (state)
            MUL_I:   begin mul_a = KI; mul_b = e; end
            MUL_D:   begin mul_a = KD; mul_b = d; end
            default: begin mul_a = KP; mul_b = e; end
        endcase
        mul_a_ext = {{N{mul_a[N-1]}}, mul_a};
        mul_b_ext = {{N{mul_b[N-1]}}, mul_b};
        prod      = mul_a_ext * mul_b_ext;
        prod_rnd  = $signed({prod[2*N-1], prod}) + RND;
        prod_sh   = prod_rnd >>> Q;
        if ((&prod_sh[2*N:N-1]) || !(|prod_sh[2*N:N-1]))
            mul_q = prod_sh[N-1:0];
        else
            mul_q = prod_sh[2*N] ? SMIN : SMAX;
    end

    // Update-stage arithmetic; hold uses the flags left by the previous update.
    logic                hold;
    logic signed [N-1:0] i_acc_new;
    logic signed [N-1:0] vcont;
    logic signed [N-1:0] vc_next;
    logic                hi_next;
    logic                lo_next;
    always_comb begin
        hold      = (sat_hi_q && !it[N-1] && (it != '0)) || (sat_lo_q && it[N-1]);
        i_acc_new = hold ? i_acc : sat1({i_acc[N-1], i_acc} + {it[N-1], it});
        vcont     = sat2({{2{p[N-1]}}, p} + {{2{i_acc_new[N-1]}}, i_acc_new}
                         + {{2{dt[N-1]}}, dt});
        vc_next   = vcont;
        hi_next   = 1'b0;
        lo_next   = 1'b0;
        if (vcont >= VMAX) begin
            vc_next = VMAX;
            hi_next = 1'b1;
        end else if (vcont <= VMIN) begin
            vc_next = VMIN;
            lo_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            vc_q        <= VMIN;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            i_acc       <= '0;
            e_prev      <= '0;
            e           <= '0;
            d           <= '0;
            p           <= '0;
            it          <= '0;
            dt          <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (clear) begin
                // Abort any in-flight sample; vc deliberately keeps its value.
                state    <= IDLE;
                i_acc    <= '0;
                e_prev   <= '0;
                sat_hi_q <= 1'b0;
                sat_lo_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.in_valid) begin
                            e     <= e_new;
                            d     <= d_new;
                            state <= MUL_P;
                        end
                    end
                    MUL_P: begin
                        p     <= mul_q;
                        state <= MUL_I;
                    end
                    MUL_I: begin
                        it    <= mul_q;
                        state <= MUL_D;
                    end
                    MUL_D: begin
                        dt    <= mul_q;
                        state <= UPDATE;
                    end
                    UPDATE: begin
                        i_acc       <= i_acc_new;
                        vc_q        <= vc_next;
                        sat_hi_q    <= hi_next;
                        sat_lo_q    <= lo_next;
                        e_prev      <= e;
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state == IDLE) && !clear;
    assign bus.out_valid = out_valid_q;
    assign bus.vc        = vc_q;
    assign bus.sat_hi    = sat_hi_q;
    assign bus.sat_lo    = sat_lo_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_pid_ctrl.sv
// Directed bench for pid_ctrl: a vector table over three gain/limit configurations
// plus hand-written sequences for throughput, clear and asynchronous reset.
module tb_pid_ctrl;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  pid_ctrl_if #(.N(N)) if_def ();
  pid_ctrl_if #(.N(N)) if_der ();
  pid_ctrl_if #(.N(N)) if_rnd ();
  logic [2:0] st_def, st_der, st_rnd;

  pid_ctrl #(.N(N)) u_def (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_def.slave), .dbg_state(st_def)
  );
  pid_ctrl #(.N(N), .KP(32'sh0), .KI(32'sh0), .KD(32'sh0800_0000)) u_der (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_der.slave), .dbg_state(st_der)
  );
  pid_ctrl #(.N(N), .KP(32'sh0800_0000), .KI(32'sh0), .KD(32'sh0),
             .VMIN(32'shC000_0000), .VMAX(32'sh4000_0000)) u_rnd (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_rnd.slave), .dbg_state(st_rnd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [N-1:0] xr, input logic [N-1:0] xm);
    case (sel)
      0: begin if_def.in_valid = v; if_def.xref = xr; if_def.xf = xm; end
      1: begin if_der.in_valid = v; if_der.xref = xr; if_der.xf = xm; end
      default: begin if_rnd.in_valid = v; if_rnd.xref = xr; if_rnd.xf = xm; end
    endcase
  endtask

  task automatic get_out(input int sel, output logic ov, output logic rdy,
                         output logic [N-1:0] vc, output logic hi, output logic lo);
    case (sel)
      0: begin ov = if_def.out_valid; rdy = if_def.in_ready; vc = if_def.vc; hi = if_def.sat_hi; lo = if_def.sat_lo; end
      1: begin ov = if_der.out_valid; rdy = if_der.in_ready; vc = if_der.vc; hi = if_der.sat_hi; lo = if_der.sat_lo; end
      default: begin ov = if_rnd.out_valid; rdy = if_rnd.in_ready; vc = if_rnd.vc; hi = if_rnd.sat_hi; lo = if_rnd.sat_lo; end
    endcase
  endtask

  // Present one sample, then count edges until out_valid (bounded at 20).
  task automatic send(input int sel, input logic [N-1:0] xr, input logic [N-1:0] xm,
                      output int lat, output logic [N-1:0] vc, output logic hi, output logic lo);
    logic ov, rdy;
    int w;
    w = 0;
    @(negedge clk);
    get_out(sel, ov, rdy, vc, hi, lo);
    while (!rdy && w < 20) begin
      @(negedge clk);
      get_out(sel, ov, rdy, vc, hi, lo);
      w++;
    end
    set_in(sel, 1'b1, xr, xm);
    @(posedge clk);
    #1 set_in(sel, 1'b0, xr, xm);
    lat = 0;
    ov = 1'b0;
    while (!ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      get_out(sel, ov, rdy, vc, hi, lo);
    end
  endtask

  typedef struct {
    int         sel;
    logic [N-1:0] xref;
    logic [N-1:0] xf;
    logic [N-1:0] exp_vc;
    logic       exp_hi;
    logic       exp_lo;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc_cnt;
    int acc_at[$];
    int ov_cnt;
    logic [N-1:0] vc;
    logic hi, lo, ov, rdy;

    // defaults: e = 0.5 until integrator winds into VMAX, then e = -0.5
    tbl[0]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h1000_0000, 1'b0, 1'b0};
    tbl[1]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h1800_0000, 1'b0, 1'b0};
    tbl[2]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h2000_0000, 1'b0, 1'b0};
    tbl[3]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h2800_0000, 1'b0, 1'b0};
    tbl[4]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h3000_0000, 1'b0, 1'b0};
    tbl[5]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h3800_0000, 1'b0, 1'b0};
    tbl[6]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 1'b1, 1'b0};
    tbl[7]  = '{0, 32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 1'b1, 1'b0};
    tbl[8]  = '{0, 32'h1000_0000, 32'h1800_0000, 32'h2800_0000, 1'b0, 1'b0};
    // derivative only, KD = 0.5
    tbl[9]  = '{1, 32'h0800_0000, 32'h0000_0000, 32'h0400_0000, 1'b0, 1'b0};
    tbl[10] = '{1, 32'h0800_0000, 32'h0000_0000, 32'h0010_0000, 1'b0, 1'b1};
    // KP = 0.5 rounding and error saturation, limits +/-4.0
    tbl[11] = '{2, 32'h0000_0003, 32'h0000_0000, 32'h0000_0002, 1'b0, 1'b0};
    tbl[12] = '{2, 32'hFFFF_FFFD, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[13] = '{2, 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 1'b1, 1'b0};

    for (int s = 0; s < 3; s++) set_in(s, 1'b0, '0, '0);

    // reset values while rst is held low
    repeat (3) @(posedge clk);
    @(negedge clk);
    get_out(0, ov, rdy, vc, hi, lo);
    check("rst_vc", vc, 32'h0010_0000);
    check("rst_ready", {31'b0, rdy}, 32'd1);
    check("rst_valid", {31'b0, ov}, 32'd0);
    check("rst_sat", {30'b0, hi, lo}, 32'd0);
    check("rst_state", {29'b0, st_def}, 32'd0);
    get_out(2, ov, rdy, vc, hi, lo);
    check("rst_vc_rnd", vc, 32'hC000_0000);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].sel, tbl[i].xref, tbl[i].xf, lat, vc, hi, lo);
      check($sformatf("vec%0d_lat", i), lat, 32'd4);
      check($sformatf("vec%0d_vc", i), vc, tbl[i].exp_vc);
      check($sformatf("vec%0d_sat", i), {30'b0, hi, lo}, {30'b0, tbl[i].exp_hi, tbl[i].exp_lo});
    end

    // in_valid held high: accepts exactly every 5 clocks (i_acc 3.0 -> 1.0, vc ends 0.5)
    @(negedge clk);
    set_in(0, 1'b1, 32'h1000_0000, 32'h1800_0000);
    acc_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (if_def.in_ready) begin
        acc_cnt++;
        acc_at.push_back(k);
      end
      @(negedge clk);
    end
    set_in(0, 1'b0, 32'h1000_0000, 32'h1800_0000);
    check("thru_count", acc_cnt, 32'd4);
    for (int j = 0; j < acc_at.size(); j++)
      check($sformatf("thru_slot%0d", j), acc_at[j], j * 5);
    repeat (6) @(negedge clk);
    check("thru_vc", if_def.vc, 32'h0800_0000);

    // clear during MUL_I aborts the sample and leaves vc alone
    @(negedge clk);
    set_in(0, 1'b1, 32'h1000_0000, 32'h0800_0000);
    @(posedge clk);
    #1 set_in(0, 1'b0, 32'h1000_0000, 32'h0800_0000);
    @(posedge clk);
    #1 check("clr_in_mul_i", {29'b0, st_def}, 32'd2);
    @(negedge clk);
    clear = 1'b1;
    #1 check("clr_ready_low", {31'b0, if_def.in_ready}, 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    ov_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 if (if_def.out_valid) ov_cnt++;
    end
    check("clr_no_valid", ov_cnt, 32'd0);
    check("clr_vc_hold", if_def.vc, 32'h0800_0000);
    send(0, 32'h1000_0000, 32'h0800_0000, lat, vc, hi, lo);
    check("clr_next_lat", lat, 32'd4);
    check("clr_next_vc", vc, 32'h1000_0000);

    // clear together with in_valid in IDLE: no accept
    @(negedge clk);
    clear = 1'b1;
    set_in(0, 1'b1, 32'h1000_0000, 32'h0800_0000);
    #1 check("clrv_ready", {31'b0, if_def.in_ready}, 32'd0);
    @(posedge clk);
    #1 begin
      clear = 1'b0;
      set_in(0, 1'b0, 32'h1000_0000, 32'h0800_0000);
    end
    check("clrv_state", {29'b0, st_def}, 32'd0);
    ov_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 if (if_def.out_valid) ov_cnt++;
    end
    check("clrv_no_valid", ov_cnt, 32'd0);

    // async reset in MUL_D, away from any clock edge
    @(negedge clk);
    set_in(0, 1'b1, 32'h1000_0000, 32'h0800_0000);
    @(posedge clk);
    #1 set_in(0, 1'b0, 32'h1000_0000, 32'h0800_0000);
    @(posedge clk);
    @(posedge clk);
    #1 check("ar_in_mul_d", {29'b0, st_def}, 32'd3);
    #2 rst = 1'b0;
    #1 begin
      get_out(0, ov, rdy, vc, hi, lo);
      check("ar_vc", vc, 32'h0010_0000);
      check("ar_ready", {31'b0, rdy}, 32'd1);
      check("ar_valid", {31'b0, ov}, 32'd0);
      check("ar_sat", {30'b0, hi, lo}, 32'd0);
      check("ar_state", {29'b0, st_def}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    send(0, 32'h1000_0000, 32'h0800_0000, lat, vc, hi, lo);
    check("ar_next_lat", lat, 32'd4);
    check("ar_next_vc", vc, 32'h1000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
